// File: rtl/sseg_scheduler_if.sv
// rtl/sseg_scheduler_if.sv - requester A/B valid/ready handshake bundle for sseg_scheduler
interface sseg_scheduler_if;
   logic        req_valid_a;
   logic [15:0] req_data_a;
   logic        req_ready_a;
   logic        req_valid_b;
   logic [15:0] req_data_b;
   logic        req_ready_b;

   modport master (
      output req_valid_a, req_data_a, req_valid_b, req_data_b,
      input  req_ready_a, req_ready_b
   );

   modport slave (
      input  req_valid_a, req_data_a, req_valid_b, req_data_b,
      output req_ready_a, req_ready_b
   );
endinterface

// File: rtl/sseg_scheduler.sv
// rtl/sseg_scheduler.sv - digit-scan prescaler plus A/B owner arbiter for a 4-digit display
// New digits are committed only at a frame boundary so one scan frame never mixes values.
module sseg_scheduler #(
   parameter int REFRESH_DIV = 100000,
   parameter int CNT_W       = $clog2(REFRESH_DIV + 1)
) (
   input  logic            clk,
   input  logic            rst,
   sseg_scheduler_if.slave req,
   output logic            scan_en,
   output logic            frame_end,
   output logic [3:0]      digit0,
   output logic [3:0]      digit1,
   output logic [3:0]      digit2,
   output logic [3:0]      digit3,
   output logic            owner
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt;
   logic             tick;
   logic [1:0]       pos, pos_n;
   logic             last_served;
   logic [15:0]      pend;
   logic             pend_src;
   logic             grant_a, grant_b;

   assign tick  = (cnt == CNT_W'(REFRESH_DIV - 1));
   // pos as it will be during the cycle being registered, so frame_end lines up with scan_en
   assign pos_n = scan_en ? pos + 2'd1 : pos;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         pos       <= 2'd0;
         scan_en   <= 1'b0;
         frame_end <= 1'b0;
      end else begin
         cnt       <= tick ? '0 : cnt + 1'b1;
         scan_en   <= tick;
         frame_end <= tick && (pos_n == 2'd3);
         pos       <= pos_n;
      end
   end

   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      state_n = state;
      case (state)
         S_IDLE: begin
            // last_served: 0 = A, 1 = B; on a tie the other side wins
            grant_a = req.req_valid_a && (!req.req_valid_b || last_served);
            grant_b = req.req_valid_b && !grant_a;
            if (grant_a || grant_b) state_n = S_WAIT;
         end
         S_WAIT: begin
            if (frame_end) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign req.req_ready_a = grant_a;
   assign req.req_ready_b = grant_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         pend        <= 16'h0000;
         pend_src    <= 1'b0;
         last_served <= 1'b1;
         digit0      <= 4'h0;
         digit1      <= 4'h0;
         digit2      <= 4'h0;
         digit3      <= 4'h0;
         owner       <= 1'b0;
      end else begin
         state <= state_n;
         if (grant_a || grant_b) begin
            pend     <= grant_a ? req.req_data_a : req.req_data_b;
            pend_src <= grant_b;
         end
         if (state == S_WAIT && frame_end) begin
            {digit3, digit2, digit1, digit0} <= pend;
            owner       <= pend_src;
            last_served <= pend_src;
         end
      end
   end

endmodule

// File: tb/tb_sseg_scheduler.sv
// tb/tb_sseg_scheduler.sv - randomized and directed bench for sseg_scheduler with a frame-arithmetic model
module tb_sseg_scheduler;
   localparam int DIV = 4;
   localparam int P   = 4 * DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scan_en, frame_end, owner;
   logic [3:0] digit0, digit1, digit2, digit3;
   logic [15:0] shown;

   sseg_scheduler_if ifc ();

   sseg_scheduler #(.REFRESH_DIV(DIV)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (ifc.slave),
      .scan_en   (scan_en),
      .frame_end (frame_end),
      .digit0    (digit0),
      .digit1    (digit1),
      .digit2    (digit2),
      .digit3    (digit3),
      .owner     (owner)
   );

   always #5 clk = ~clk;
   assign shown = {digit3, digit2, digit1, digit0};

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   // reference model: a transfer at cycle c becomes visible right after the next frame multiple above c
   logic [15:0] m_digits;
   logic        m_owner, m_last, m_busy, m_src;
   logic [15:0] m_pend;
   int          m_load;
   logic        e_ra, e_rb, e_scan, e_fe;

   task automatic model_reset();
      m_digits = 16'h0; m_owner = 1'b0; m_last = 1'b1;
      m_busy = 1'b0; m_pend = 16'h0; m_src = 1'b0; m_load = -1;
      e_ra = 1'b0; e_rb = 1'b0;
   endtask

   task automatic model_eval(input logic va, input logic [15:0] da, input logic vb, input logic [15:0] db);
      if (m_busy && cyc == m_load) begin
         m_digits = m_pend; m_owner = m_src; m_last = m_src; m_busy = 1'b0;
      end
      e_ra = 1'b0; e_rb = 1'b0;
      if (!m_busy) begin
         if (va && (!vb || m_last)) e_ra = 1'b1;
         else if (vb) e_rb = 1'b1;
         if (e_ra || e_rb) begin
            m_pend = e_ra ? da : db;
            m_src  = e_rb;
            m_busy = 1'b1;
            m_load = (cyc / P + 1) * P + 1;
         end
      end
      e_scan = (cyc > 0) && (cyc % DIV == 0);
      e_fe   = (cyc > 0) && (cyc % P == 0);
   endtask

   task automatic drive(input logic va, input logic [15:0] da, input logic vb, input logic [15:0] db);
      ifc.req_valid_a = va; ifc.req_data_a = da;
      ifc.req_valid_b = vb; ifc.req_data_b = db;
   endtask

   task automatic tick(input logic va, input logic [15:0] da, input logic vb, input logic [15:0] db);
      @(posedge clk);
      cyc++;
      #1;
      drive(va, da, vb, db);
      model_eval(va, da, vb, db);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 16'h0, 1'b0, 16'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic test_reset();
      drive(1'b0, 16'h0, 1'b0, 16'h0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_total++;
      if ({shown, owner, scan_en, frame_end, ifc.req_ready_a, ifc.req_ready_b} !== 21'h0)
         $display("FAIL reset_outputs got digits=%h owner=%b scan=%b fe=%b ra=%b rb=%b need all 0",
                  shown, owner, scan_en, frame_end, ifc.req_ready_a, ifc.req_ready_b);
      else n_pass++;
   endtask

   task automatic test_scan_timing();
      do_reset();
      for (int c = 1; c <= 36; c++) begin
         tick(1'b0, 16'h0, 1'b0, 16'h0);
         n_total++;
         if (scan_en !== (c % DIV == 0) || frame_end !== (c % P == 0) || shown !== 16'h0 || owner !== 1'b0)
            $display("FAIL scan_timing cyc=%0d got scan=%b fe=%b digits=%h owner=%b need scan=%b fe=%b digits=0 owner=0",
                     c, scan_en, frame_end, shown, owner, c % DIV == 0, c % P == 0);
         else n_pass++;
      end
   endtask

   task automatic test_single_a();
      do_reset();
      for (int c = 1; c <= 18; c++) begin
         tick(c == 5, 16'h1234, 1'b0, 16'h0);
         if (c == 5) begin
            n_total++;
            if (ifc.req_ready_a !== 1'b1) $display("FAIL single_a_ready got %b need 1", ifc.req_ready_a);
            else n_pass++;
         end
         if (c == 16 || c == 17) begin
            n_total++;
            if (shown !== (c == 17 ? 16'h1234 : 16'h0) || owner !== 1'b0)
               $display("FAIL single_a_load cyc=%0d got %h owner=%b need %h owner=0",
                        c, shown, owner, c == 17 ? 16'h1234 : 16'h0);
            else n_pass++;
         end
      end
   endtask

   task automatic test_both_valid();
      logic va, vb;
      va = 1'b0; vb = 1'b0;
      do_reset();
      for (int c = 1; c <= 34; c++) begin
         if (c == 2) begin va = 1'b1; vb = 1'b1; end
         tick(va, 16'hAAAA, vb, 16'hBBBB);
         if (c == 2 || c == 17) begin
            n_total++;
            if (ifc.req_ready_a !== (c == 2) || ifc.req_ready_b !== (c == 17))
               $display("FAIL both_grant cyc=%0d got ra=%b rb=%b need ra=%b rb=%b",
                        c, ifc.req_ready_a, ifc.req_ready_b, c == 2, c == 17);
            else n_pass++;
         end
         if (e_ra) va = 1'b0;
         if (e_rb) vb = 1'b0;
         if (c == 17 || c == 33) begin
            n_total++;
            if (shown !== (c == 17 ? 16'hAAAA : 16'hBBBB) || owner !== (c == 33))
               $display("FAIL both_load cyc=%0d got %h owner=%b need %h owner=%b",
                        c, shown, owner, c == 17 ? 16'hAAAA : 16'hBBBB, c == 33);
            else n_pass++;
         end
      end
   endtask

   task automatic test_capture_at_frame();
      do_reset();
      for (int c = 1; c <= 34; c++) begin
         tick(c == 16, 16'h00F0, 1'b0, 16'h0);
         if (c == 16) begin
            n_total++;
            if (ifc.req_ready_a !== 1'b1 || frame_end !== 1'b1)
               $display("FAIL frame_capture_ready got ra=%b fe=%b need 1 1", ifc.req_ready_a, frame_end);
            else n_pass++;
         end
         if (c == 17 || c == 32 || c == 33) begin
            n_total++;
            if (shown !== (c == 33 ? 16'h00F0 : 16'h0))
               $display("FAIL frame_capture_load cyc=%0d got %h need %h", c, shown, c == 33 ? 16'h00F0 : 16'h0);
            else n_pass++;
         end
      end
   endtask

   task automatic test_random();
      logic va, vb;
      logic [15:0] da, db;
      do_reset();
      for (int c = 1; c <= 400; c++) begin
         va = ($urandom % 4) != 0;
         vb = ($urandom % 3) != 0;
         da = 16'($urandom);
         db = 16'($urandom);
         tick(va, da, vb, db);
         n_total++;
         if (ifc.req_ready_a !== e_ra || ifc.req_ready_b !== e_rb || scan_en !== e_scan ||
             frame_end !== e_fe || shown !== m_digits || owner !== m_owner)
            $display("FAIL random cyc=%0d got ra=%b rb=%b scan=%b fe=%b digits=%h owner=%b need ra=%b rb=%b scan=%b fe=%b digits=%h owner=%b",
                     c, ifc.req_ready_a, ifc.req_ready_b, scan_en, frame_end, shown, owner,
                     e_ra, e_rb, e_scan, e_fe, m_digits, m_owner);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int loads;
      logic prev_owner;
      loads = 0;
      prev_owner = 1'b1;
      do_reset();
      for (int c = 1; c <= 6 * P + 2; c++) begin
         tick(1'b1, 16'($urandom), 1'b1, 16'($urandom));
         n_total++;
         if (ifc.req_ready_a !== e_ra || ifc.req_ready_b !== e_rb || shown !== m_digits || owner !== m_owner)
            $display("FAIL back_to_back cyc=%0d got ra=%b rb=%b digits=%h owner=%b need ra=%b rb=%b digits=%h owner=%b",
                     c, ifc.req_ready_a, ifc.req_ready_b, shown, owner, e_ra, e_rb, m_digits, m_owner);
         else n_pass++;
         if (c > P && c % P == 1) begin
            loads++;
            n_total++;
            if (owner !== ~prev_owner)
               $display("FAIL back_to_back_alternate load=%0d got owner=%b need %b", loads, owner, ~prev_owner);
            else n_pass++;
            prev_owner = ~prev_owner;
         end
      end
   endtask

   task automatic test_reset_mid();
      rst = 1'b1;
      #1;
      n_total++;
      if (shown !== 16'h0 || owner !== 1'b0)
         $display("FAIL async_clear got digits=%h owner=%b need 0 0", shown, owner);
      else n_pass++;
      do_reset();
      for (int c = 1; c <= 10; c++) begin
         tick(c == 3, 16'h5555, 1'b0, 16'h0);
         if (c == 3) begin
            n_total++;
            if (ifc.req_ready_a !== 1'b1) $display("FAIL reset_mid_ready got %b need 1", ifc.req_ready_a);
            else n_pass++;
         end
      end
      do_reset();
      for (int c = 1; c <= 36; c++) begin
         tick(1'b0, 16'h0, 1'b0, 16'h0);
         n_total++;
         if (shown !== 16'h0 || scan_en !== (c % DIV == 0))
            $display("FAIL reset_mid cyc=%0d got digits=%h scan=%b need digits=0 scan=%b",
                     c, shown, scan_en, c % DIV == 0);
         else n_pass++;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_scan_timing();
      test_single_a();
      test_both_valid();
      test_capture_at_frame();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/sseg_scheduler.md
Name: sseg_scheduler

Overview:
Scheduler and owner arbiter for the 4-digit seven-segment display path. It generates the digit-scan enable pulse and frame boundary, and arbitrates between two requesters (A, B) that want to show a 16-bit value. The winning value is applied to the digit outputs only at a frame boundary, so a scan frame never mixes old and new digits. Its outputs feed the display driver's enable and digit0..digit3 inputs.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit-scan step; legal range >= 1.
CNT_W, $clog2(REFRESH_DIV+1), prescaler counter width.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
req_valid_a  input  1  requester A has a value to show.
req_data_a  input  16  A's value; [3:0] goes to digit0, [15:12] to digit3.
req_ready_a  output  1  A's transfer accepted this cycle.
req_valid_b  input  1  requester B valid.
req_data_b  input  16  B's value, same packing as A.
req_ready_b  output  1  B's transfer accepted this cycle.
scan_en  output  1  one-cycle pulse that advances the display digit scan.
frame_end  output  1  one-cycle pulse on the 4th scan_en of each frame.
digit0  output  4  displayed nibble 0.
digit1  output  4  displayed nibble 1.
digit2  output  4  displayed nibble 2.
digit3  output  4  displayed nibble 3.
owner  output  1  source of the current digits: 0 = A, 1 = B.

Behaviour:
- Reset (async, while rst=1):
  - All outputs are 0: digits, owner, scan_en, frame_end, req_ready_a, req_ready_b.
  - Prescaler cnt=0, scan position pos=0.
  - FSM is in IDLE, the pending buffer is empty, and last_served=B, so A wins the first tie.
- Prescaler:
  - cnt counts 0..REFRESH_DIV-1 and wraps.
  - scan_en is registered and is 1 in the cycle after cnt==REFRESH_DIV-1.
  - After reset release, the first scan_en appears REFRESH_DIV cycles later.
  - With REFRESH_DIV=1, scan_en is constantly 1 after reset.
- Scan position:
  - pos (2 bits) increments on each scan_en and wraps 3->0.
  - frame_end=1 in the same cycle as the scan_en that occurs while pos==3. Frame period is 4*REFRESH_DIV cycles.
- Arbiter FSM, states IDLE and WAIT:
  - IDLE:
    - The grant goes to the single valid requester. If both are valid, the grant goes to the requester that is not last_served.
    - The granted requester's ready is combinationally 1 (valid and ready in the same cycle).
    - On transfer: pend <= data, pend_src <= grantee, go to WAIT.
    - The non-granted ready is 0. With no valid request, both readies are 0.
  - WAIT:
    - Both readies are 0.
    - On the first frame_end strictly after the capture cycle, load {digit3..digit0} <= pend, owner <= pend_src, last_served <= pend_src, and return to IDLE.
    - A capture in the same cycle as a frame_end waits for the next frame_end, i.e. 4*REFRESH_DIV cycles later.
- Load timing:
  - Worst-case capture-to-display latency is 4*REFRESH_DIV+1 cycles.
  - The digits are stable for the whole frame in which they were loaded.
- Requester rules:
  - A requester may drop valid before ready without effect; nothing is captured.
  - Data is sampled only in the transfer cycle.
  - A requester kept waiting keeps valid high. There is no timeout.
- Reset mid-operation: pending data is discarded, digits are cleared immediately, and no load occurs after release until a new transfer.
- Width rules: no arithmetic on the data; the nibbles are passed through unchanged (0x0-0xF).

Test Plan:
1. REFRESH_DIV=4; release rst at cycle 0 -> scan_en at cycles 4, 8, 12, 16…; frame_end only at 16, 32…; digits=0 and owner=0 throughout.
2. A valid with 0x1234 at cycle 5 -> req_ready_a=1 at cycle 5; digits unchanged until the cycle after frame_end@16; then digit0=4, digit1=3, digit2=2, digit3=1, owner=0.
3. A=0xAAAA and B=0xBBBB both valid from cycle 2 -> A granted at 2 and loaded at frame 16; B granted in IDLE after that load and loaded at frame 32; owner goes 0 then 1.
4. A and B held valid continuously for 6 frames -> owner alternates A, B, A, B…; a ready never asserts while in WAIT.
5. A transfers 0x00F0 in the same cycle as frame_end@16 -> digits are unchanged at 16 and updated only after frame_end@32.
6. A transfers 0x5555 at cycle 3, then rst pulses at cycle 10 -> digits stay 0; no load at the following frame_end; scan_en restarts 4 cycles after release.
